// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory read port plus the IR handshake to the decoder.
// The fetch unit drives the address and IR; memory and decoder return data and J_EN.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] imem_addr;
    logic [9:0]        imem_rdata;
    logic [9:0]        IR;
    logic              IRload;
    logic              J_EN;

    modport master (
        output imem_addr,
        output IR,
        output IRload,
        input  imem_rdata,
        input  J_EN
    );

    modport slave (
        input  imem_addr,
        input  IR,
        input  IRload,
        output imem_rdata,
        output J_EN
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencer: four-cycle FETCH/LOAD/DECODE/EXEC loop feeding the
// decoder's IR bus, with jump redirect, HALT detection and a saturating retire count.
module instr_fetch_unit #(
    parameter int ADDR_W     = 4,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    instr_fetch_unit_if.master   bus,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted,
    output logic                 busy,
    output logic [CNT_W-1:0]     retired
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [3:0]        OP_HALT  = 4'b0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t state;

    // NOTE: all state and outputs are registered with non-blocking assignments so every
    // branch below sees the values from before this edge, and nothing combinational leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc            <= START_PC;
            bus.imem_addr <= START_PC;
            bus.IR        <= '0;
            bus.IRload    <= 1'b0;
            halted        <= 1'b0;
            busy          <= 1'b0;
            retired       <= '0;
        end else begin
            bus.IRload <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= START_PC;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    bus.imem_addr <= pc;
                    state         <= S_LOAD;
                end
                S_LOAD: begin
                    bus.IR     <= bus.imem_rdata;
                    bus.IRload <= 1'b1;
                    state      <= S_DECODE;
                end
                S_DECODE: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // HALT outranks a concurrent jump request from the decoder.
                    if (bus.IR[9:6] == OP_HALT) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_HALTED;
                    end else begin
                        if (bus.J_EN) begin
                            pc <= bus.IR[ADDR_W-1:0];
                        end else begin
                            pc <= pc + 1'b1;
                        end
                        if (retired != '1) begin
                            retired <= retired + 1'b1;
                        end
                        state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        pc     <= pc + 1'b1;
                        halted <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    halted <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential run, jumps, HALT/restart, PC wrap,
// retire saturation, mid-run reset and ignored start/J_EN.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 4;

    localparam logic [9:0] W_ADD   = 10'b0001_00_0011;
    localparam logic [9:0] W_SUB   = 10'b0010_00_0110;
    localparam logic [9:0] W_OR    = 10'b0011_00_1100;
    localparam logic [9:0] W_JMP9  = 10'b0101_00_1001;
    localparam logic [9:0] W_JMP5  = 10'b0101_00_0101;
    localparam logic [9:0] W_JMP15 = 10'b0101_00_1111;
    localparam logic [9:0] W_JMP3  = 10'b0101_00_0011;
    localparam logic [9:0] W_HALT  = 10'b0000_00_0111;
    localparam logic [9:0] W_ADDHI = 10'b0001_11_0110;
    localparam logic [9:0] W_FILL  = 10'b0111_00_1110;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              j_force;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              busy;
    logic [7:0]        retired;
    logic [9:0]        mem [16];

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(0),
        .CNT_W     (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus.master),
        .pc     (pc),
        .halted (halted),
        .busy   (busy),
        .retired(retired)
    );

    // Memory answers the registered address in the following cycle; a toy decoder
    // raises J_EN for JMP words, and j_force lets the bench inject stray requests.
    assign bus.imem_rdata = mem[bus.imem_addr];
    assign bus.J_EN       = j_force | (bus.IR[9:6] == 4'b0101);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        j_force = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = W_FILL;
        mem[0]  = W_ADD;
        mem[1]  = W_SUB;
        mem[2]  = W_OR;
        mem[3]  = W_JMP9;
        mem[9]  = W_JMP5;
        mem[5]  = W_HALT;
        mem[6]  = W_JMP15;
        mem[15] = W_ADDHI;

        // Reset values
        #12;
        check("rst_pc",      32'(pc), 32'd0);
        check("rst_addr",    32'(bus.imem_addr), 32'd0);
        check("rst_ir",      32'(bus.IR), 32'd0);
        check("rst_irload",  32'(bus.IRload), 32'd0);
        check("rst_halted",  32'(halted), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("idle_busy", 32'(busy), 32'd0);

        // Sequential run of ADD, SUB, OR
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("e0_busy",   32'(busy), 32'd1);
        check("e0_pc",     32'(pc), 32'd0);
        check("e0_irload", 32'(bus.IRload), 32'd0);
        tick(2);
        check("e2_irload", 32'(bus.IRload), 32'd1);
        check("e2_ir",     32'(bus.IR), 32'(W_ADD));
        check("e2_pc",     32'(pc), 32'd0);
        tick(1);
        check("e3_irload", 32'(bus.IRload), 32'd0);
        tick(3);
        check("e6_irload", 32'(bus.IRload), 32'd1);
        check("e6_ir",     32'(bus.IR), 32'(W_SUB));
        check("e6_pc",     32'(pc), 32'd1);
        tick(4);
        check("e10_irload", 32'(bus.IRload), 32'd1);
        check("e10_ir",     32'(bus.IR), 32'(W_OR));
        check("e10_pc",     32'(pc), 32'd2);
        tick(2);
        check("e12_retired", 32'(retired), 32'd3);
        check("e12_pc",      32'(pc), 32'd3);

        // Jump from 3 to 9, then 9 to 5
        tick(1);
        check("e13_addr", 32'(bus.imem_addr), 32'd3);
        tick(1);
        check("e14_ir", 32'(bus.IR), 32'(W_JMP9));
        tick(2);
        check("jmp9_pc",      32'(pc), 32'd9);
        check("jmp9_retired", 32'(retired), 32'd4);
        tick(1);
        check("jmp9_addr", 32'(bus.imem_addr), 32'd9);
        tick(1);
        check("e18_ir", 32'(bus.IR), 32'(W_JMP5));
        tick(2);
        check("jmp5_pc",      32'(pc), 32'd5);
        check("jmp5_retired", 32'(retired), 32'd5);

        // HALT at 5 with a stray J_EN during its EXEC
        tick(2);
        check("halt_ir", 32'(bus.IR), 32'(W_HALT));
        tick(1);
        j_force = 1'b1;
        tick(1);
        j_force = 1'b0;
        check("halt_halted",  32'(halted), 32'd1);
        check("halt_busy",    32'(busy), 32'd0);
        check("halt_pc",      32'(pc), 32'd5);
        check("halt_retired", 32'(retired), 32'd5);
        check("halt_ir_keep", 32'(bus.IR), 32'(W_HALT));
        tick(5);
        check("halt_hold",         32'(halted), 32'd1);
        check("halt_retired_hold", 32'(retired), 32'd5);
        check("halt_pc_hold",      32'(pc), 32'd5);

        // Restart from HALT fetches from 6, which jumps to 15
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("restart_pc",     32'(pc), 32'd6);
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_busy",   32'(busy), 32'd1);
        tick(1);
        check("restart_addr", 32'(bus.imem_addr), 32'd6);
        tick(1);
        check("h2_ir", 32'(bus.IR), 32'(W_JMP15));
        tick(2);
        check("jmp15_pc",      32'(pc), 32'd15);
        check("jmp15_retired", 32'(retired), 32'd6);
        tick(4);
        check("wrap_pc",      32'(pc), 32'd0);
        check("wrap_retired", 32'(retired), 32'd7);

        // Tight loop at 3 drives retired into saturation
        mem[3] = W_JMP3;
        for (int i = 0; i < 2000 && retired != 8'd254; i++) tick(1);
        check("sat_reach_254", 32'(retired), 32'd254);
        check("loop_pc",       32'(pc), 32'd3);
        tick(4);
        check("sat_255", 32'(retired), 32'd255);
        tick(8);
        check("sat_hold",  32'(retired), 32'd255);
        check("loop_pc2",  32'(pc), 32'd3);
        check("loop_addr", 32'(bus.imem_addr), 32'd3);

        // Reset asserted while in DECODE
        for (int i = 0; i < 10 && bus.IRload !== 1'b1; i++) tick(1);
        check("pre_rst_irload", 32'(bus.IRload), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ir",      32'(bus.IR), 32'd0);
        check("mrst_pc",      32'(pc), 32'd0);
        check("mrst_irload",  32'(bus.IRload), 32'd0);
        check("mrst_retired", 32'(retired), 32'd0);
        check("mrst_busy",    32'(busy), 32'd0);
        check("mrst_addr",    32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        check("mrst_idle_busy", 32'(busy), 32'd0);
        check("mrst_idle_pc",   32'(pc), 32'd0);
        check("mrst_idle_ld",   32'(bus.IRload), 32'd0);

        // start held high through the run; J_EN pulsed during DECODE
        mem[3] = W_ADD;
        start = 1'b1;
        tick(1);
        check("s6_e0_pc",   32'(pc), 32'd0);
        check("s6_e0_busy", 32'(busy), 32'd1);
        tick(2);
        check("s6_e2_ir", 32'(bus.IR), 32'(W_ADD));
        j_force = 1'b1;
        tick(1);
        j_force = 1'b0;
        tick(1);
        check("s6_e4_pc",   32'(pc), 32'd1);
        check("s6_e4_busy", 32'(busy), 32'd1);
        tick(2);
        check("s6_e6_ir", 32'(bus.IR), 32'(W_SUB));
        check("s6_e6_pc", 32'(pc), 32'd1);
        tick(2);
        check("s6_e8_pc", 32'(pc), 32'd2);
        start = 1'b0;
        tick(4);
        check("s6_e12_pc",      32'(pc), 32'd3);
        check("s6_e12_retired", 32'(retired), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
